// File: rtl/sample_page_logger.sv
// Multi-channel ADC sample logger: decimates, packs samples into ping-pong
// EEPROM-page buffers and hands full or flushed pages to the EEPROM writer.
module sample_page_logger #(
    parameter  int SAMPLE_W   = 8,
    parameter  int CHANNELS   = 2,
    parameter  int PAGE_BYTES = 64,
    parameter  int ADDR_W     = 16,
    parameter  int DECIM_W    = 8,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IDX_W      = $clog2(PAGE_BYTES),
    localparam int LEN_W      = IDX_W + 1
) (
    input  logic                CLK_50MHz,
    input  logic                RESET,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_word,
    input  logic [CH_W-1:0]     sample_chan,
    input  logic [CHANNELS-1:0] chan_enable,
    input  logic [DECIM_W-1:0]  decim,
    input  logic                flush,
    output logic                page_ready,
    output logic [ADDR_W-1:0]   page_addr,
    output logic [LEN_W-1:0]    page_len,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [7:0]          rd_data,
    input  logic                page_done,
    output logic                overflow,
    output logic [15:0]         dropped_count
);

    localparam int BPS   = (SAMPLE_W <= 8) ? 1 : 2;
    localparam int PAD_W = 8 * BPS;

    logic [7:0]         r_mem [2][PAGE_BYTES];
    logic [DECIM_W-1:0] r_dcnt [CHANNELS];
    logic               r_fill_bank;
    logic               r_fill_full;   // fill bank is FULL (else FILLING)
    logic               r_pub;         // other bank is PUBLISHED (else FREE)
    logic [LEN_W-1:0]   r_wr_ptr;
    logic [LEN_W-1:0]   r_full_len;
    logic               r_page_ready;
    logic [ADDR_W-1:0]  r_page_addr;
    logic [LEN_W-1:0]   r_page_len;
    logic [7:0]         r_rd_data;
    logic               r_overflow;
    logic [15:0]        r_dropped;

    logic [CHANNELS-1:0] w_chan_hit;
    logic                w_accept;
    logic                w_busy;
    logic                w_store;
    logic                w_drop;
    logic                w_tgt_bank;
    logic [LEN_W-1:0]    w_base;
    logic [LEN_W-1:0]    w_new_ptr;
    logic                w_make_full;
    logic [PAD_W-1:0]    w_padded;

    // A FULL bank that is publishing this cycle hands new samples to the
    // bank being freed, so a sample arriving in the publish cycle is kept.
    always_comb begin
        w_chan_hit = '0;
        w_accept   = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_chan_hit[c] = sample_valid && (sample_chan == CH_W'(c)) && chan_enable[c];
            if (w_chan_hit[c] && (r_dcnt[c] == '0)) w_accept = 1'b1;
        end
        w_busy      = r_fill_full && r_pub;
        w_store     = w_accept && !w_busy;
        w_drop      = w_accept && w_busy;
        w_tgt_bank  = r_fill_full ? ~r_fill_bank : r_fill_bank;
        w_base      = r_fill_full ? '0 : r_wr_ptr;
        w_new_ptr   = w_base + (w_store ? LEN_W'(BPS) : '0);
        w_make_full = (w_new_ptr == LEN_W'(PAGE_BYTES)) || (flush && (w_new_ptr != '0));
        w_padded    = PAD_W'(sample_word);
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            r_fill_bank  <= 1'b0;
            r_fill_full  <= 1'b0;
            r_pub        <= 1'b0;
            r_wr_ptr     <= '0;
            r_full_len   <= '0;
            r_page_ready <= 1'b0;
            r_page_addr  <= '0;
            r_page_len   <= '0;
            r_overflow   <= 1'b0;
            r_dropped    <= '0;
            for (int c = 0; c < CHANNELS; c++) r_dcnt[c] <= '0;
        end else begin
            if (r_fill_full && !r_pub) begin
                r_fill_bank  <= ~r_fill_bank;
                r_pub        <= 1'b1;
                r_page_ready <= 1'b1;
                r_page_len   <= r_full_len;
                r_wr_ptr     <= w_new_ptr;
                r_fill_full  <= w_make_full;
                r_full_len   <= w_new_ptr;
            end else if (!r_fill_full) begin
                if (w_make_full && !r_pub) begin
                    r_fill_bank  <= ~r_fill_bank;
                    r_pub        <= 1'b1;
                    r_page_ready <= 1'b1;
                    r_page_len   <= w_new_ptr;
                    r_wr_ptr     <= '0;
                end else begin
                    r_wr_ptr    <= w_new_ptr;
                    r_fill_full <= w_make_full;
                    r_full_len  <= w_new_ptr;
                end
            end

            if (page_done && r_page_ready) begin
                r_pub        <= 1'b0;
                r_page_ready <= 1'b0;
                r_page_addr  <= r_page_addr + ADDR_W'(PAGE_BYTES);
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
            end

            for (int c = 0; c < CHANNELS; c++) begin
                if (w_chan_hit[c]) r_dcnt[c] <= (r_dcnt[c] == decim) ? '0 : r_dcnt[c] + 1'b1;
            end
        end
    end

    // NOTE: the page memory is reset so reads past page_len never return X.
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < PAGE_BYTES; i++) r_mem[b][i] <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_store) begin
                for (int k = 0; k < BPS; k++)
                    r_mem[w_tgt_bank][w_base[IDX_W-1:0] + IDX_W'(k)] <= w_padded[8*k +: 8];
            end
            r_rd_data <= r_mem[~r_fill_bank][rd_idx];
        end
    end

    assign page_ready    = r_page_ready;
    assign page_addr     = r_page_addr;
    assign page_len      = r_page_len;
    assign rd_data       = r_rd_data;
    assign overflow      = r_overflow;
    assign dropped_count = r_dropped;

endmodule
